mac_out_requant: RTL and testbench



---
 rtl/mac_out_requant.sv | 110 +++++++++++
 tb/tb_mac_out_requant.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_out_requant.sv
// Output stage after the MAC array: captures an MxN accumulator matrix, requantizes
// each element (shift + saturate) and streams it one row per beat. Define ROUND_HALF_UP_EN for rounding.
module mac_out_requant #(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int OUT_WIDTH = 8,
    localparam int ROW_W    = (M > 1) ? $clog2(M) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic signed [M-1:0][N-1:0][31:0]    D_in,
    input  logic        [4:0]                   shift_i,
    input  logic                                valid_in,
    output logic                                ready_in,
    output logic        [N-1:0][OUT_WIDTH-1:0]  row_o,
    output logic        [ROW_W-1:0]             row_idx_o,
    output logic                                last_o,
    output logic                                valid_out,
    input  logic                                ready_out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic signed [32:0] MAXV = 33'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [32:0] MINV = -MAXV - 33'sd1;

    state_t state_p0, state_nxt;
    logic [ROW_W-1:0] row_p0, row_nxt;
    logic signed [31:0] mat_p0 [M][N];
    logic [4:0] shamt_p0;
    logic capture;

    // 33-bit headroom keeps the rounding increment from overflowing at 0x7FFFFFFF
    function automatic logic signed [32:0] shift_round(input logic signed [31:0] x,
                                                       input logic [4:0] s);
        logic signed [32:0] xe;
        xe = {x[31], x};
`ifdef ROUND_HALF_UP_EN
        if (s != 5'd0)
            xe = xe + (33'sd1 <<< (s - 5'd1));
`endif
        return xe >>> s;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [32:0] y);
        logic signed [32:0] r;
        if (y > MAXV)
            r = MAXV;
        else if (y < MINV)
            r = MINV;
        else
            r = y;
        return r[OUT_WIDTH-1:0];
    endfunction

    assign valid_out = (state_p0 == SEND);
    assign last_o    = (state_p0 == SEND) && (row_p0 == ROW_W'(M - 1));
    assign ready_in  = (state_p0 == IDLE) || (last_o && ready_out);
    assign capture   = valid_in && ready_in;
    assign row_idx_o = row_p0;

    always_comb begin
        state_nxt = state_p0;
        row_nxt   = row_p0;
        if (capture) begin
            // a new matrix may replace the final beat of the old one with no bubble
            state_nxt = SEND;
            row_nxt   = '0;
        end else if ((state_p0 == SEND) && ready_out) begin
            if (last_o) begin
                state_nxt = IDLE;
                row_nxt   = '0;
            end else begin
                row_nxt = row_p0 + ROW_W'(1);
            end
        end
    end

    // ---- stage p0: capture buffer and row sequencer ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p0 <= IDLE;
            row_p0   <= '0;
            shamt_p0 <= '0;
            for (int r = 0; r < M; r++)
                for (int c = 0; c < N; c++)
                    mat_p0[r][c] <= '0;
        end else begin
            state_p0 <= state_nxt;
            row_p0   <= row_nxt;
            if (capture) begin
                shamt_p0 <= shift_i;
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < N; c++)
                        mat_p0[r][c] <= $signed(D_in[r][c]);
            end
        end
    end

    // ---- output: requantize the selected row straight from the buffer ----
    always_comb begin
        row_o = '0;
        for (int c = 0; c < N; c++)
            row_o[c] = sat(shift_round(mat_p0[row_p0][c], shamt_p0));
    end

endmodule

// File: tb/tb_mac_out_requant.sv
// Randomized + directed bench for mac_out_requant against a queue-based beat model.
module tb_mac_out_requant;

    localparam int M = 2;
    localparam int N = 2;
    localparam int OUT_WIDTH = 8;
    localparam int ROW_W = 1;

    logic clk_i = 1'b0;
    logic rst_i;
    logic signed [M-1:0][N-1:0][31:0] D_in;
    logic [4:0] shift_i;
    logic valid_in;
    logic ready_in;
    logic [N-1:0][OUT_WIDTH-1:0] row_o;
    logic [ROW_W-1:0] row_idx_o;
    logic last_o;
    logic valid_out;
    logic ready_out;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int el [N];
        int idx;
        int lst;
    } beat_t;
    beat_t q[$];

    mac_out_requant #(.M(M), .N(N), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .D_in(D_in), .shift_i(shift_i),
        .valid_in(valid_in), .ready_in(ready_in), .row_o(row_o),
        .row_idx_o(row_idx_o), .last_o(last_o), .valid_out(valid_out),
        .ready_out(ready_out)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference requantization: floor (or round-half-up) divide by 2^s, then clamp.
    function automatic int requant(input int x, input int s);
        longint y;
        longint hi;
        longint lo;
        y = longint'(x);
`ifdef ROUND_HALF_UP_EN
        if (s > 0) y = y + (longint'(1) << (s - 1));
`endif
        y = y >>> s;
        hi = (longint'(1) << (OUT_WIDTH - 1)) - 1;
        lo = -(longint'(1) << (OUT_WIDTH - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return int'(y);
    endfunction

    // Model bookkeeping: a capture queues M beats; each accepted beat pops one.
    always @(posedge clk_i) begin
        bit mdl_rdy;
        beat_t b;
        if (rst_i) begin
            q.delete();
        end else begin
            mdl_rdy = (q.size() == 0) || (q.size() == 1 && ready_out);
            if (q.size() > 0 && ready_out) void'(q.pop_front());
            if (valid_in && mdl_rdy) begin
                for (int r = 0; r < M; r++) begin
                    for (int c = 0; c < N; c++)
                        b.el[c] = requant(int'(D_in[r][c]), int'(shift_i));
                    b.idx = r;
                    b.lst = (r == M - 1) ? 1 : 0;
                    q.push_back(b);
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("mon_valid_out", valid_out, (q.size() != 0) ? 1 : 0);
            chk("mon_ready_in", ready_in,
                ((q.size() == 0) || (q.size() == 1 && ready_out)) ? 1 : 0);
            if (q.size() != 0 && valid_out) begin
                for (int c = 0; c < N; c++)
                    chk("mon_row_o", $signed(row_o[c]), q[0].el[c]);
                chk("mon_row_idx", row_idx_o, q[0].idx);
                chk("mon_last", last_o, q[0].lst);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int a, input int b, input int c, input int d, input int sh);
        D_in[0][0] = a;
        D_in[0][1] = b;
        D_in[1][0] = c;
        D_in[1][1] = d;
        shift_i = 5'(sh);
    endtask

    task automatic capture();
        int n;
        valid_in = 1'b1;
        #1;
        n = 0;
        while (!ready_in && n < 20) begin
            tick();
            n++;
        end
        chk("capture_ready_in", ready_in, 1);
        tick();
        valid_in = 1'b0;
        #1;
    endtask

    task automatic beat(input string nm, input int e0, input int e1, input int idx, input int lst);
        chk({nm, "_e0"}, $signed(row_o[0]), e0);
        chk({nm, "_e1"}, $signed(row_o[1]), e1);
        chk({nm, "_valid"}, valid_out, 1);
        chk({nm, "_idx"}, row_idx_o, idx);
        chk({nm, "_last"}, last_o, lst);
    endtask

    function automatic int rnd32();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom);
            1: v = int'($urandom_range(0, 600)) - 300;
            2: v = ($urandom_range(0, 1) != 0) ? int'(32'h8000_0000) : int'(32'h7FFF_FFFF);
            default: v = int'($urandom >> $urandom_range(0, 31));
        endcase
        return v;
    endfunction

    initial begin
        bit pend;
        bit acc;
        rst_i = 1'b1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        load(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_last", last_o, 0);
        chk("rst_row_idx", row_idx_o, 0);
        chk("rst_row_o", row_o, 0);
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Basic saturation
        load(100, -100, 300, -300, 0);
        capture();
        beat("basic_b0", 100, -100, 0, 0);
        tick();
        beat("basic_b1", 127, -128, 1, 1);
        tick();
        chk("basic_idle", valid_out, 0);

        // Rounding mode
        load(6, -6, 5, -5, 2);
        capture();
`ifdef ROUND_HALF_UP_EN
        beat("round_b0", 2, -1, 0, 0);
        tick();
        beat("round_b1", 1, -1, 1, 1);
`else
        beat("round_b0", 1, -2, 0, 0);
        tick();
        beat("round_b1", 1, -2, 1, 1);
`endif
        tick();

        // Extreme shift
        load(int'(32'h8000_0000), int'(32'h7FFF_FFFF), 1, -1, 31);
        capture();
`ifdef ROUND_HALF_UP_EN
        beat("ext_b0", -1, 1, 0, 0);
        tick();
        beat("ext_b1", 0, 0, 1, 1);
`else
        beat("ext_b0", -1, 0, 0, 0);
        tick();
        beat("ext_b1", 0, -1, 1, 1);
`endif
        tick();

        // Backpressure on beat 0
        load(1, 2, 3, 4, 0);
        capture();
        ready_out = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            beat("bp_hold", 1, 2, 0, 0);
            chk("bp_ready_in", ready_in, 0);
            tick();
        end
        ready_out = 1'b1;
        #1;
        beat("bp_release", 1, 2, 0, 0);
        tick();
        beat("bp_b1", 3, 4, 1, 1);
        tick();

        // Back-to-back matrices
        load(10, 20, 30, 40, 0);
        valid_in = 1'b1;
        tick();
        load(5, 6, -7, 8, 0);
        #1;
        beat("b2b_a0", 10, 20, 0, 0);
        chk("b2b_a0_ready_in", ready_in, 0);
        tick();
        beat("b2b_a1", 30, 40, 1, 1);
        chk("b2b_a1_ready_in", ready_in, 1);
        tick();
        valid_in = 1'b0;
        #1;
        beat("b2b_b0", 5, 6, 0, 0);
        tick();
        beat("b2b_b1", -7, 8, 1, 1);
        tick();
        chk("b2b_idle", valid_out, 0);

        // Reset during beat 1
        load(50, 60, 70, 80, 0);
        capture();
        tick();
        beat("rstmid_b1", 70, 80, 1, 1);
        rst_i = 1'b1;
        tick();
        chk("rstmid_valid_out", valid_out, 0);
        chk("rstmid_ready_in", ready_in, 1);
        chk("rstmid_row_o", row_o, 0);
        chk("rstmid_row_idx", row_idx_o, 0);
        rst_i = 1'b0;

        // Randomized traffic; the source holds data until accepted
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                load(rnd32(), rnd32(), rnd32(), rnd32(), int'($urandom_range(0, 31)));
                pend = 1'b1;
            end
            valid_in = pend;
            ready_out = ($urandom_range(0, 3) != 0);
            #1;
            acc = valid_in && ready_in;
            tick();
            if (acc) pend = 1'b0;
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("drain_empty", valid_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
